multu_seq: RTL and testbench

- Iterative unsigned 32x32 multiplier for the MULTU instruction; produces a 64-bit product split into hi and lo.
- Sits in the EX stage beside the divide unit and uses the same start/busy stall handshake, so the control unit treats both units identically.
- Radix-2 shift-add, one multiplier bit per cycle, fixed latency.

---
 rtl/cpu_arith_pkg.sv | 13 +
 rtl/multu_seq.sv | 86 ++++++++
 tb/tb_multu_seq.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_arith_pkg.sv
// Shared constants and control-state encoding for the EX-stage iterative
// arithmetic units (multiply and divide).
package cpu_arith_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } arith_state_e;

endpackage : cpu_arith_pkg

// File: rtl/multu_seq.sv
// Iterative radix-2 shift-add unsigned multiplier for MULTU. One multiplier
// bit is retired per falling clock edge, so the result appears after WIDTH iterations.
module multu_seq
    import cpu_arith_pkg::*;
#(
    parameter int WIDTH = cpu_arith_pkg::WIDTH,
    parameter int CNT_W = cpu_arith_pkg::CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             start,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    arith_state_e     state_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] mq_q;
    logic [WIDTH-1:0] mc_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   acc_d;
    logic [WIDTH-1:0] mq_d;

    // acc_q[WIDTH] is always zero after a shift, so adding the full acc_q
    // is the same as adding its low WIDTH bits.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        addend = mq_q[0] ? {1'b0, mc_q} : '0;
        sum    = acc_q + addend;
        acc_d  = {1'b0, sum[WIDTH:1]};
        mq_d   = {sum[0], mq_q[WIDTH-1:1]};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mq_q    <= '0;
            mc_q    <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                // A start while running discards the operation in flight.
                state_q <= RUN;
                acc_q   <= '0;
                mq_q    <= multiplier;
                mc_q    <= multiplicand;
                count_q <= '0;
            end else if (state_q == RUN) begin
                acc_q   <= acc_d;
                mq_q    <= mq_d;
                count_q <= count_q + 1'b1;
                if (count_q == CNT_LAST) begin
                    state_q <= IDLE;
                    hi_q    <= acc_d[WIDTH-1:0];
                    lo_q    <= mq_d;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule : multu_seq

// File: tb/tb_multu_seq.sv
// Directed bench for multu_seq: table of hand-computed products plus
// abort, mid-operation reset and back-to-back sequences.
module tb_multu_seq;

    localparam int W = 32;

    logic         clock = 1'b1;
    logic         reset;
    logic [W-1:0] multiplicand;
    logic [W-1:0] multiplier;
    logic         start;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    multu_seq dut (
        .clock       (clock),
        .reset       (reset),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .start       (start),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done)
    );

    // DUT updates on falling edges; the bench drives and samples on rising edges.
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller must be at a rising edge; start is seen by exactly one falling edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clock);
        start        = 1'b0;
    endtask

    task automatic run_to_done(output int cycles, output int early_done);
        cycles     = 0;
        early_done = 0;
        do begin
            @(posedge clock);
            cycles++;
            if (busy && done) early_done++;
        end while (busy && cycles < 40);
    endtask

    vec_t vecs[7];
    int   cyc;
    int   early;
    int   busy_seen;
    int   done_seen;

    initial begin
        vecs[0] = '{32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        vecs[3] = '{32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[6] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001};

        reset        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi",   64'(hi),   64'd0);
        check("reset_lo",   64'(lo),   64'd0);

        @(posedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        check("idle_busy", 64'(busy), 64'd0);

        foreach (vecs[i]) begin
            @(posedge clock);
            launch(vecs[i].a, vecs[i].b);
            check("busy_after_start", 64'(busy), 64'd1);
            run_to_done(cyc, early);
            check("latency",    64'(cyc),   64'd32);
            check("early_done", 64'(early), 64'd0);
            check("done_pulse", 64'(done),  64'd1);
            check("vec_hi",     64'(hi),    64'(vecs[i].exp_hi));
            check("vec_lo",     64'(lo),    64'(vecs[i].exp_lo));
            @(posedge clock);
            check("done_clear", 64'(done),  64'd0);
            check("hold_lo",    64'(lo),    64'(vecs[i].exp_lo));
        end

        // Abort: 7x9 restarted at iteration 10 with 0x10000 x 0x10000.
        @(posedge clock);
        launch(32'd7, 32'd9);
        done_seen = 0;
        repeat (10) begin
            @(posedge clock);
            if (done) done_seen++;
        end
        check("abort_busy",    64'(busy),      64'd1);
        check("abort_no_done", 64'(done_seen), 64'd0);
        launch(32'h0001_0000, 32'h0001_0000);
        check("abort_hold_lo", 64'(lo), 64'hFFFE_0001);
        run_to_done(cyc, early);
        check("abort_latency",    64'(cyc),   64'd32);
        check("abort_early_done", 64'(early), 64'd0);
        check("abort_done",       64'(done),  64'd1);
        check("abort_hi",         64'(hi),    64'h0000_0001);
        check("abort_lo",         64'(lo),    64'h0000_0000);

        // Asynchronous reset at iteration 20 of 100x100, between clock edges.
        @(posedge clock);
        launch(32'd100, 32'd100);
        repeat (19) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset_busy", 64'(busy), 64'd0);
        check("mid_reset_done", 64'(done), 64'd0);
        check("mid_reset_hi",   64'(hi),   64'd0);
        check("mid_reset_lo",   64'(lo),   64'd0);
        @(posedge clock);
        reset     = 1'b1;
        busy_seen = 0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clock);
            if (busy) busy_seen++;
            if (done) done_seen++;
        end
        check("post_reset_idle",    64'(busy_seen), 64'd0);
        check("post_reset_no_done", 64'(done_seen), 64'd0);
        check("post_reset_lo",      64'(lo),        64'd0);

        // Back-to-back: second start presented while done is high.
        @(posedge clock);
        launch(32'd6, 32'd7);
        run_to_done(cyc, early);
        check("b2b_first_done", 64'(done), 64'd1);
        check("b2b_first_lo",   64'(lo),   64'd42);
        launch(32'd11, 32'd13);
        check("b2b_busy",      64'(busy), 64'd1);
        check("b2b_done_low",  64'(done), 64'd0);
        check("b2b_hold_lo",   64'(lo),   64'd42);
        run_to_done(cyc, early);
        check("b2b_latency",     64'(cyc),  64'd32);
        check("b2b_second_done", 64'(done), 64'd1);
        check("b2b_second_hi",   64'(hi),   64'd0);
        check("b2b_second_lo",   64'(lo),   64'd143);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_multu_seq
